// File: rtl/port_rd_sgdma_if.sv
// Handshake bundle between the egress SGDMA and its neighbours: the crossbar
// descriptor FIFO, the MMU read port, the port output FIFO and the free
// pointer list. Signal names keep the i_/o_ direction prefix as seen from
// the DMA, so the master modport is the DMA itself.
interface port_rd_sgdma_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int CNT_WIDTH  = 8,
  parameter int DISP_WIDTH = ADDR_WIDTH + CNT_WIDTH + 7
);
  // Descriptor FIFO (standard FIFO: data valid the cycle after the pop)
  logic                  o_cb_rd_en;
  logic [DISP_WIDTH-1:0] i_cb_dout;
  logic                  i_cb_empty;
  // MMU read port
  logic                  o_mmu_rd_req;
  logic [ADDR_WIDTH-1:0] o_mmu_rd_addr;
  logic                  i_mmu_rd_ready;
  logic                  i_mmu_rd_vld;
  logic [DATA_WIDTH-1:0] i_mmu_rd_dat;
  // Port output FIFO
  logic                  o_out_wr_en;
  logic [DATA_WIDTH-1:0] o_out_dat;
  logic                  o_out_sop;
  logic                  o_out_eop;
  logic                  i_out_full;
  // Free pointer list
  logic                  o_fp_wr_en;
  logic [ADDR_WIDTH-1:0] o_fp_din;
  logic                  i_fp_full;
  // Status
  logic                  o_busy;
  logic                  o_desc_err;

  modport master (
    output o_cb_rd_en, o_mmu_rd_req, o_mmu_rd_addr, o_out_wr_en, o_out_dat,
           o_out_sop, o_out_eop, o_fp_wr_en, o_fp_din, o_busy, o_desc_err,
    input  i_cb_dout, i_cb_empty, i_mmu_rd_ready, i_mmu_rd_vld, i_mmu_rd_dat,
           i_out_full, i_fp_full
  );

  modport slave (
    input  o_cb_rd_en, o_mmu_rd_req, o_mmu_rd_addr, o_out_wr_en, o_out_dat,
           o_out_sop, o_out_eop, o_fp_wr_en, o_fp_din, o_busy, o_desc_err,
    output i_cb_dout, i_cb_empty, i_mmu_rd_ready, i_mmu_rd_vld, i_mmu_rd_dat,
           i_out_full, i_fp_full
  );
endinterface

// File: rtl/port_rd_sgdma.sv
// Output-port read-side scatter-gather DMA.
// Pops a dispatch descriptor, reads the packet's consecutive SRAM units
// through the MMU, streams them to the port output FIFO framed with sop/eop,
// and hands every read address back to the free pointer list once its data
// has returned. Reads in flight plus buffered words never exceed RBUF_DEPTH,
// so returning data never needs backpressure.
module port_rd_sgdma #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int CNT_WIDTH  = 8,
  parameter int DISP_WIDTH = ADDR_WIDTH + CNT_WIDTH + 7,
  parameter int RBUF_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  port_rd_sgdma_if.master bus
);

  localparam int PTR_W = $clog2(RBUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(RBUF_DEPTH);
  localparam logic [OCC_W:0]   DEPTH_SUM = (OCC_W + 1)'(RBUF_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DESC,
    ST_ISSUE,
    ST_DRAIN
  } state_t;

  // Control state
  state_t                state_q;
  logic                  arm_q;
  logic [ADDR_WIDTH-1:0] issue_addr_q;
  logic [CNT_WIDTH-1:0]  issue_left_q;
  logic [CNT_WIDTH-1:0]  drain_left_q;
  logic [CNT_WIDTH-1:0]  unit_cnt_q;
  logic [OCC_W-1:0]      inflight_q;

  // Return buffer: read data waiting for room in the output FIFO
  logic [DATA_WIDTH-1:0] rb_mem [RBUF_DEPTH];
  logic [PTR_W-1:0]      rb_wp_q;
  logic [PTR_W-1:0]      rb_rp_q;
  logic [OCC_W-1:0]      rb_cnt_q;

  // Free queue: accepted read addresses, released in read order
  logic [ADDR_WIDTH-1:0] fq_mem [RBUF_DEPTH];
  logic [PTR_W-1:0]      fq_wp_q;
  logic [PTR_W-1:0]      fq_rp_q;
  logic [OCC_W-1:0]      fq_cnt_q;
  logic [OCC_W-1:0]      ret_cnt_q;

  // Descriptor fields {first_addr, unit_cnt, pri, dest}; pri/dest travel in
  // the packet head word, so only address and count matter here.
  logic [ADDR_WIDTH-1:0] desc_addr;
  logic [CNT_WIDTH-1:0]  desc_cnt;
  assign desc_addr = bus.i_cb_dout[DISP_WIDTH-1 -: ADDR_WIDTH];
  assign desc_cnt  = bus.i_cb_dout[DISP_WIDTH-ADDR_WIDTH-1 -: CNT_WIDTH];

  // Handshake terms shared by the FSM, the counters and the outputs
  logic credit;
  logic fq_full;
  logic cb_pop;
  logic desc_zero;
  logic rd_req;
  logic rd_acc;
  logic vld_ok;
  logic out_pop;
  logic fp_pop;

  // Decode this cycle's handshakes from registered state and live inputs
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    credit    = 1'b0;
    fq_full   = 1'b0;
    cb_pop    = 1'b0;
    desc_zero = 1'b0;
    rd_req    = 1'b0;
    rd_acc    = 1'b0;
    vld_ok    = 1'b0;
    out_pop   = 1'b0;
    fp_pop    = 1'b0;

    credit    = ({1'b0, inflight_q} + {1'b0, rb_cnt_q}) < DEPTH_SUM;
    fq_full   = (fq_cnt_q == DEPTH_OCC);
    // arm_q keeps the pop low while reset is held and for the first cycle after
    cb_pop    = (state_q == ST_IDLE) && arm_q && !bus.i_cb_empty;
    desc_zero = (state_q == ST_DESC) && (desc_cnt == '0);
    rd_req    = (state_q == ST_ISSUE) && (issue_left_q != '0) && credit && !fq_full;
    rd_acc    = rd_req && bus.i_mmu_rd_ready;
    // Data with nothing in flight (e.g. left over from before a reset) is dropped
    vld_ok    = bus.i_mmu_rd_vld && (inflight_q != '0);
    out_pop   = (rb_cnt_q != '0) && !bus.i_out_full;
    fp_pop    = (ret_cnt_q != '0) && !bus.i_fp_full;
  end

  // Packet sequencing: descriptor fetch, read issue and drain
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      arm_q        <= 1'b0;
      issue_addr_q <= '0;
      issue_left_q <= '0;
      drain_left_q <= '0;
      unit_cnt_q   <= '0;
    end else begin
      arm_q <= 1'b1;
      if (out_pop) begin
        drain_left_q <= drain_left_q - CNT_WIDTH'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (cb_pop) begin
            state_q <= ST_DESC;
          end
        end
        ST_DESC: begin
          issue_addr_q <= desc_addr;
          issue_left_q <= desc_cnt;
          drain_left_q <= desc_cnt;
          unit_cnt_q   <= desc_cnt;
          state_q      <= desc_zero ? ST_IDLE : ST_ISSUE;
        end
        ST_ISSUE: begin
          if (rd_acc) begin
            // Address wraps naturally at 2^ADDR_WIDTH
            issue_addr_q <= issue_addr_q + ADDR_WIDTH'(1);
            issue_left_q <= issue_left_q - CNT_WIDTH'(1);
            if (issue_left_q == CNT_WIDTH'(1)) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if ((drain_left_q == '0) && (fq_cnt_q == '0)) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Occupancy counters; a simultaneous +1/-1 leaves a counter unchanged
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight_q <= '0;
      rb_cnt_q   <= '0;
      fq_cnt_q   <= '0;
      ret_cnt_q  <= '0;
    end else begin
      inflight_q <= inflight_q + OCC_W'(rd_acc) - OCC_W'(vld_ok);
      rb_cnt_q   <= rb_cnt_q   + OCC_W'(vld_ok) - OCC_W'(out_pop);
      fq_cnt_q   <= fq_cnt_q   + OCC_W'(rd_acc) - OCC_W'(fp_pop);
      ret_cnt_q  <= ret_cnt_q  + OCC_W'(vld_ok) - OCC_W'(fp_pop);
    end
  end

  // Ring pointers for the return buffer and the free queue
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rb_wp_q <= '0;
      rb_rp_q <= '0;
      fq_wp_q <= '0;
      fq_rp_q <= '0;
    end else begin
      if (vld_ok)  rb_wp_q <= rb_wp_q + PTR_W'(1);
      if (out_pop) rb_rp_q <= rb_rp_q + PTR_W'(1);
      if (rd_acc)  fq_wp_q <= fq_wp_q + PTR_W'(1);
      if (fp_pop)  fq_rp_q <= fq_rp_q + PTR_W'(1);
    end
  end

  // Storage writes: returning data and accepted addresses
  // NOTE: storage arrays carry no reset; the occupancy counters alone say which entries are valid.
  always_ff @(posedge i_clk) begin
    if (vld_ok) rb_mem[rb_wp_q] <= bus.i_mmu_rd_dat;
    if (rd_acc) fq_mem[fq_wp_q] <= issue_addr_q;
  end

  // Outputs: data buses are gated by their strobes so they read 0 when idle
  assign bus.o_cb_rd_en    = cb_pop;
  assign bus.o_mmu_rd_req  = rd_req;
  assign bus.o_mmu_rd_addr = issue_addr_q;
  assign bus.o_out_wr_en   = out_pop;
  assign bus.o_out_dat     = out_pop ? rb_mem[rb_rp_q] : '0;
  assign bus.o_out_sop     = out_pop && (drain_left_q == unit_cnt_q);
  assign bus.o_out_eop     = out_pop && (drain_left_q == CNT_WIDTH'(1));
  assign bus.o_fp_wr_en    = fp_pop;
  assign bus.o_fp_din      = fp_pop ? fq_mem[fq_rp_q] : '0;
  assign bus.o_busy        = (state_q != ST_IDLE);
  assign bus.o_desc_err    = desc_zero;

endmodule

// File: tb/tb_port_rd_sgdma.sv
// Bench for port_rd_sgdma: a descriptor FIFO model, an MMU with fixed read
// latency, and scoreboards of expected reads, output words and free pushes
// filled when each descriptor is queued and drained as the DUT acts.
module tb_port_rd_sgdma;
  localparam int DW  = 32;
  localparam int AW  = 17;
  localparam int CW  = 8;
  localparam int LAT = 2;

  typedef struct {
    logic [DW-1:0] dat;
    logic          sop;
    logic          eop;
  } out_t;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
  } pend_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  port_rd_sgdma_if bus ();

  port_rd_sgdma dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0]   desc_q [$];
  logic [AW-1:0] exp_rd [$];
  logic [AW-1:0] exp_fp [$];
  out_t          exp_out[$];
  pend_t         pend   [$];

  int            cyc           = 0;
  bit            pop_pend      = 1'b0;
  int            tb_inflight   = 0;
  int            acc_total     = 0;
  int            out_total     = 0;
  int            occ_max       = 0;
  int            stall_after   = 0;
  int            stall_len     = 0;
  int            stall_left    = 0;
  int            acc_since     = 0;
  int            stall_req     = 0;
  int            hold_bad      = 0;
  logic [AW-1:0] hold_addr     = '0;
  int            full_left     = 0;
  int            err_pulses    = 0;
  int            pop_cyc       = -1;
  int            first_req_cyc = -1;

  logic [AW-1:0] mon_a;
  out_t          mon_o;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[14:0], a} ^ 32'h5A3C_0000;
  endfunction

  // Queue a descriptor and everything it must produce
  task automatic push_desc(input logic [AW-1:0] addr, input int cnt);
    logic [AW-1:0] a;
    out_t          o;
    desc_q.push_back({addr, CW'(cnt), 3'd2, 4'd5});
    for (int i = 0; i < cnt; i++) begin
      a = addr + AW'(i);
      exp_rd.push_back(a);
      exp_fp.push_back(a);
      o.dat = mem_word(a);
      o.sop = (i == 0);
      o.eop = (i == cnt - 1);
      exp_out.push_back(o);
    end
  endtask

  // Bounded wait for all expectations to be consumed and the DUT to go idle
  task automatic wait_done(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #2;
      done = (exp_out.size() == 0) && (exp_rd.size() == 0) && (exp_fp.size() == 0) &&
             (desc_q.size() == 0) && !pop_pend && (bus.o_busy == 1'b0);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_done: left out=%0d rd=%0d fp=%0d busy=%0b, expected all 0",
               name, exp_out.size(), exp_rd.size(), exp_fp.size(), bus.o_busy);
    end
  endtask

  // Environment model: drives inputs on the falling edge, then samples
  // the DUT 1 time unit later to score what the next rising edge commits.
  initial begin
    bus.i_cb_dout      = '0;
    bus.i_cb_empty     = 1'b1;
    bus.i_mmu_rd_ready = 1'b1;
    bus.i_mmu_rd_vld   = 1'b0;
    bus.i_mmu_rd_dat   = '0;
    bus.i_out_full     = 1'b0;
    bus.i_fp_full      = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pop_pend) begin
        bus.i_cb_dout = desc_q.pop_front();
        pop_pend      = 1'b0;
      end
      bus.i_cb_empty = (desc_q.size() == 0);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.i_mmu_rd_vld = 1'b1;
        bus.i_mmu_rd_dat = mem_word(pend[0].addr);
        void'(pend.pop_front());
        if (tb_inflight > 0) tb_inflight--;
      end else begin
        bus.i_mmu_rd_vld = 1'b0;
        bus.i_mmu_rd_dat = $urandom;
      end
      bus.i_mmu_rd_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      bus.i_out_full = (full_left > 0);
      if (full_left > 0) full_left--;
      #1;
      if (rst_n) begin
        if (bus.o_cb_rd_en) begin
          pop_pend = 1'b1;
          pop_cyc  = cyc;
        end
        if (bus.o_mmu_rd_req && first_req_cyc < 0) first_req_cyc = cyc;
        if (bus.o_mmu_rd_req && !bus.i_mmu_rd_ready) begin
          stall_req++;
          if (bus.o_mmu_rd_addr !== hold_addr) hold_bad++;
        end
        if (bus.o_mmu_rd_req && bus.i_mmu_rd_ready) begin
          checks++;
          if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL rd_addr: unexpected read of 0x%05h", bus.o_mmu_rd_addr);
          end else begin
            mon_a = exp_rd.pop_front();
            if (bus.o_mmu_rd_addr !== mon_a) begin
              errors++;
              $display("FAIL rd_addr: got 0x%05h, expected 0x%05h", bus.o_mmu_rd_addr, mon_a);
            end
          end
          pend.push_back('{cyc + LAT, bus.o_mmu_rd_addr});
          tb_inflight++;
          acc_total++;
          acc_since++;
          if (stall_after != 0 && acc_since == stall_after) stall_left = stall_len;
        end
        if (bus.o_out_wr_en) begin
          checks++;
          out_total++;
          if (exp_out.size() == 0) begin
            errors++;
            $display("FAIL out_word: unexpected word 0x%08h", bus.o_out_dat);
          end else begin
            mon_o = exp_out.pop_front();
            if ({bus.o_out_dat, bus.o_out_sop, bus.o_out_eop} !== {mon_o.dat, mon_o.sop, mon_o.eop}) begin
              errors++;
              $display("FAIL out_word: got dat=0x%08h sop=%0b eop=%0b, expected dat=0x%08h sop=%0b eop=%0b",
                       bus.o_out_dat, bus.o_out_sop, bus.o_out_eop, mon_o.dat, mon_o.sop, mon_o.eop);
            end
          end
        end
        if (bus.o_fp_wr_en) begin
          checks++;
          if (exp_fp.size() == 0) begin
            errors++;
            $display("FAIL fp_push: unexpected free of 0x%05h", bus.o_fp_din);
          end else begin
            mon_a = exp_fp.pop_front();
            if (bus.o_fp_din !== mon_a) begin
              errors++;
              $display("FAIL fp_push: got 0x%05h, expected 0x%05h", bus.o_fp_din, mon_a);
            end
          end
        end
        if (bus.o_desc_err) err_pulses++;
        if (acc_total - out_total > occ_max) occ_max = acc_total - out_total;
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({bus.o_cb_rd_en, bus.o_mmu_rd_req, bus.o_out_wr_en, bus.o_out_sop, bus.o_out_eop,
         bus.o_fp_wr_en, bus.o_busy, bus.o_desc_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %08b, expected 00000000",
               {bus.o_cb_rd_en, bus.o_mmu_rd_req, bus.o_out_wr_en, bus.o_out_sop, bus.o_out_eop,
                bus.o_fp_wr_en, bus.o_busy, bus.o_desc_err});
    end
    checks++;
    if ({bus.o_mmu_rd_addr, bus.o_out_dat, bus.o_fp_din} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=0x%05h dat=0x%08h fp=0x%05h, expected all 0",
               bus.o_mmu_rd_addr, bus.o_out_dat, bus.o_fp_din);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    pop_cyc       = -1;
    first_req_cyc = -1;
    push_desc(17'h00010, 1);
    wait_done("single", 200);
    checks++;
    if (first_req_cyc - pop_cyc !== 2) begin
      errors++;
      $display("FAIL single_req_latency: got %0d cycles, expected 2", first_req_cyc - pop_cyc);
    end
  endtask

  task automatic test_wrap();
    push_desc(17'h1FFFE, 4);
    wait_done("wrap", 200);
  endtask

  task automatic test_ready_stall();
    acc_since   = 0;
    stall_req   = 0;
    hold_bad    = 0;
    hold_addr   = 17'h00302;
    stall_len   = 5;
    stall_after = 2;
    push_desc(17'h00300, 6);
    wait_done("stall", 200);
    stall_after = 0;
    checks++;
    if (stall_req !== 5) begin
      errors++;
      $display("FAIL stall_req_held: got %0d cycles, expected 5", stall_req);
    end
    checks++;
    if (hold_bad !== 0) begin
      errors++;
      $display("FAIL stall_addr_hold: got %0d moved cycles, expected 0", hold_bad);
    end
  endtask

  task automatic test_out_full();
    occ_max   = 0;
    full_left = 20;
    push_desc(17'h00400, 10);
    wait_done("full", 400);
    checks++;
    if (occ_max !== 4) begin
      errors++;
      $display("FAIL full_occupancy: got max %0d, expected 4", occ_max);
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    e0 = err_pulses;
    push_desc(17'h00500, 3);
    push_desc(17'h00600, 0);
    push_desc(17'h00700, 2);
    wait_done("b2b", 300);
    checks++;
    if (err_pulses - e0 !== 1) begin
      errors++;
      $display("FAIL b2b_desc_err: got %0d pulses, expected 1", err_pulses - e0);
    end
  endtask

  task automatic test_mid_reset();
    bit hit;
    hit       = 1'b0;
    acc_since = 0;
    push_desc(17'h00800, 8);
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      #2;
      hit = (acc_since >= 2) && (tb_inflight == 2);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mreset_inflight: got inflight %0d, expected 2", tb_inflight);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_cb_rd_en, bus.o_mmu_rd_req, bus.o_out_wr_en, bus.o_out_sop, bus.o_out_eop,
         bus.o_fp_wr_en, bus.o_busy, bus.o_desc_err} !== 8'h00) begin
      errors++;
      $display("FAIL mreset_ctrl: got %08b, expected 00000000",
               {bus.o_cb_rd_en, bus.o_mmu_rd_req, bus.o_out_wr_en, bus.o_out_sop, bus.o_out_eop,
                bus.o_fp_wr_en, bus.o_busy, bus.o_desc_err});
    end
    checks++;
    if ({bus.o_mmu_rd_addr, bus.o_out_dat, bus.o_fp_din} !== '0) begin
      errors++;
      $display("FAIL mreset_data: got addr=0x%05h dat=0x%08h fp=0x%05h, expected all 0",
               bus.o_mmu_rd_addr, bus.o_out_dat, bus.o_fp_din);
    end
    // The dropped packet owes nothing; reads still pending in the MMU model
    // come back after reset and must be ignored.
    desc_q.delete();
    exp_rd.delete();
    exp_fp.delete();
    exp_out.delete();
    pop_pend    = 1'b0;
    tb_inflight = 0;
    acc_total   = 0;
    out_total   = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mreset_idle: got busy=%0b, expected 0", bus.o_busy);
    end
    push_desc(17'h00900, 3);
    wait_done("after_reset", 200);
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_ready_stall();
    test_out_full();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
